physics_step_scheduler: RTL and testbench

PHYSICS_STEP_SCHEDULER -- requirements
Module: physics_step_scheduler

---
 rtl/physics_step_scheduler.sv | 175 +++++++++++++++++
 tb/tb_physics_step_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/physics_step_scheduler.sv
// Physics step sequencer: kicks the springs engine, integrates the per-node force
// stream into velocity/position with saturation and a floor clamp, and guards with a watchdog.
module physics_step_scheduler #(
    parameter int NUM_NODES     = 8,
    parameter int POSITION_SIZE = 16,
    parameter int VELOCITY_SIZE = 16,
    parameter int FORCE_SIZE    = 16,
    parameter int DT_SHIFT      = 4,
    parameter int GRAVITY       = -16,
    parameter int FLOOR_Y       = 0,
    parameter int TIMEOUT       = 4096
) (
    input  logic                                           clk_in,
    input  logic                                           rst_in,
    input  logic                                           step_trigger,
    input  logic                                           load_valid,
    input  logic [$clog2(NUM_NODES)-1:0]                   load_idx,
    input  logic signed [POSITION_SIZE-1:0]                load_pos_x,
    input  logic signed [POSITION_SIZE-1:0]                load_pos_y,
    input  logic signed [VELOCITY_SIZE-1:0]                load_vel_x,
    input  logic signed [VELOCITY_SIZE-1:0]                load_vel_y,
    output logic                                           springs_start,
    input  logic signed [FORCE_SIZE-1:0]                   spring_force_x,
    input  logic signed [FORCE_SIZE-1:0]                   spring_force_y,
    input  logic                                           spring_force_valid,
    input  logic                                           springs_done,
    output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]   nodes,
    output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]   velocities,
    output logic                                           busy,
    output logic                                           step_done,
    output logic [7:0]                                     overrun_count,
    output logic                                           error
);

    localparam int IDX_W = $clog2(NUM_NODES);
    localparam int CNT_W = $clog2(NUM_NODES + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int MAXW  = (FORCE_SIZE > VELOCITY_SIZE)
                         ? ((FORCE_SIZE > POSITION_SIZE) ? FORCE_SIZE : POSITION_SIZE)
                         : ((VELOCITY_SIZE > POSITION_SIZE) ? VELOCITY_SIZE : POSITION_SIZE);
    localparam int W     = MAXW + 2;

    localparam logic [CNT_W-1:0]                N_LAST  = CNT_W'(NUM_NODES);
    localparam logic [WD_W-1:0]                 WD_LOAD = WD_W'(TIMEOUT - 1);
    localparam logic signed [W-1:0]             G_W     = W'(GRAVITY);
    localparam logic signed [POSITION_SIZE-1:0] FLOOR_P = POSITION_SIZE'(FLOOR_Y);
    localparam logic signed [W-1:0] V_MAX = {{(W-VELOCITY_SIZE+1){1'b0}}, {(VELOCITY_SIZE-1){1'b1}}};
    localparam logic signed [W-1:0] V_MIN = {{(W-VELOCITY_SIZE+1){1'b1}}, {(VELOCITY_SIZE-1){1'b0}}};
    localparam logic signed [W-1:0] P_MAX = {{(W-POSITION_SIZE+1){1'b0}}, {(POSITION_SIZE-1){1'b1}}};
    localparam logic signed [W-1:0] P_MIN = {{(W-POSITION_SIZE+1){1'b1}}, {(POSITION_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, START, COLLECT, DONE} state_t;

    state_t            state;
    logic              pending;
    logic [CNT_W-1:0]  force_idx;
    logic [WD_W-1:0]   wdog;

    logic [IDX_W-1:0]                sel;
    logic signed [POSITION_SIZE-1:0] cur_px, cur_py, pnew_x, pnew_y, pfin_y;
    logic signed [VELOCITY_SIZE-1:0] cur_vx, cur_vy, vnew_x, vnew_y, vfin_y;
    logic signed [W-1:0]             vsum_x, vsum_y, psum_x, psum_y;
    logic                            take;
    logic [CNT_W-1:0]                post_idx;

    function automatic logic signed [VELOCITY_SIZE-1:0] sat_v(input logic signed [W-1:0] x);
        if (x > V_MAX) return V_MAX[VELOCITY_SIZE-1:0];
        if (x < V_MIN) return V_MIN[VELOCITY_SIZE-1:0];
        return x[VELOCITY_SIZE-1:0];
    endfunction

    function automatic logic signed [POSITION_SIZE-1:0] sat_p(input logic signed [W-1:0] x);
        if (x > P_MAX) return P_MAX[POSITION_SIZE-1:0];
        if (x < P_MIN) return P_MIN[POSITION_SIZE-1:0];
        return x[POSITION_SIZE-1:0];
    endfunction

    assign busy = (state != IDLE) || pending;

    // Integrator for the node currently addressed by the force stream.
    always_comb begin
        sel    = force_idx[IDX_W-1:0];
        cur_px = nodes[0][sel];
        cur_py = nodes[1][sel];
        cur_vx = velocities[0][sel];
        cur_vy = velocities[1][sel];
        vsum_x = W'(cur_vx) + (W'(spring_force_x) >>> DT_SHIFT);
        vsum_y = W'(cur_vy) + ((W'(spring_force_y) + G_W) >>> DT_SHIFT);
        vnew_x = sat_v(vsum_x);
        vnew_y = sat_v(vsum_y);
        psum_x = W'(cur_px) + (W'(vnew_x) >>> DT_SHIFT);
        psum_y = W'(cur_py) + (W'(vnew_y) >>> DT_SHIFT);
        pnew_x = sat_p(psum_x);
        pnew_y = sat_p(psum_y);
        pfin_y = pnew_y;
        vfin_y = vnew_y;
        if (pnew_y < FLOOR_P) begin
            pfin_y = FLOOR_P;
            if (vnew_y[VELOCITY_SIZE-1]) vfin_y = '0;
        end
        take     = spring_force_valid && (force_idx < N_LAST);
        post_idx = force_idx + CNT_W'(take);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            pending       <= 1'b0;
            force_idx     <= '0;
            wdog          <= '0;
            springs_start <= 1'b0;
            step_done     <= 1'b0;
            overrun_count <= '0;
            error         <= 1'b0;
            nodes         <= '0;
            velocities    <= '0;
        end else begin
            springs_start <= 1'b0;
            step_done     <= 1'b0;

            // One trigger may queue behind a running step; further ones are counted as lost.
            if (state != IDLE && step_trigger) begin
                if (!pending) pending <= 1'b1;
                else if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (load_valid) begin
                        nodes[0][load_idx]      <= load_pos_x;
                        nodes[1][load_idx]      <= load_pos_y;
                        velocities[0][load_idx] <= load_vel_x;
                        velocities[1][load_idx] <= load_vel_y;
                    end
                    if (step_trigger || pending) begin
                        pending       <= pending && step_trigger;
                        springs_start <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    force_idx <= '0;
                    wdog      <= WD_LOAD;
                    state     <= COLLECT;
                end
                COLLECT: begin
                    if (spring_force_valid) begin
                        if (take) begin
                            nodes[0][sel]      <= pnew_x;
                            nodes[1][sel]      <= pfin_y;
                            velocities[0][sel] <= vnew_x;
                            velocities[1][sel] <= vfin_y;
                            force_idx          <= post_idx;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    if (springs_done) begin
                        if (post_idx < N_LAST) error <= 1'b1;
                        step_done <= 1'b1;
                        state     <= DONE;
                    end else if (wdog == '0) begin
                        error     <= 1'b1;
                        step_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wdog <= wdog - WD_W'(1);
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_physics_step_scheduler.sv
// Scoreboard bench for physics_step_scheduler: an integer reference model predicts
// node state per step, checked when step_done fires, plus targeted control-path tests.
module tb_physics_step_scheduler;

    localparam int N = 4, PS = 16, VS = 16, FS = 16, DT = 2, G = -8, FLOOR = 0, TO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, step_trigger = 1'b0, load_valid = 1'b0;
    logic [1:0] load_idx = '0;
    logic signed [PS-1:0] load_pos_x = '0, load_pos_y = '0;
    logic signed [VS-1:0] load_vel_x = '0, load_vel_y = '0;
    logic signed [FS-1:0] fx = '0, fy = '0;
    logic fvalid = 1'b0, sdone = 1'b0;
    logic springs_start, busy, step_done, error;
    logic [7:0] overrun_count;
    logic [1:0][N-1:0][PS-1:0] nodes;
    logic [1:0][N-1:0][VS-1:0] velocities;

    physics_step_scheduler #(
        .NUM_NODES(N), .POSITION_SIZE(PS), .VELOCITY_SIZE(VS), .FORCE_SIZE(FS),
        .DT_SHIFT(DT), .GRAVITY(G), .FLOOR_Y(FLOOR), .TIMEOUT(TO)
    ) dut (
        .clk_in(clk), .rst_in(rst), .step_trigger(step_trigger),
        .load_valid(load_valid), .load_idx(load_idx),
        .load_pos_x(load_pos_x), .load_pos_y(load_pos_y),
        .load_vel_x(load_vel_x), .load_vel_y(load_vel_y),
        .springs_start(springs_start),
        .spring_force_x(fx), .spring_force_y(fy), .spring_force_valid(fvalid),
        .springs_done(sdone), .nodes(nodes), .velocities(velocities),
        .busy(busy), .step_done(step_done), .overrun_count(overrun_count), .error(error)
    );

    int checks = 0, failures = 0;
    int sd_cnt = 0, ss_cnt = 0;
    always @(posedge clk) begin
        if (step_done) sd_cnt++;
        if (springs_start) ss_cnt++;
    end

    int mpx[N], mpy[N], mvx[N], mvy[N];
    bit merr;
    int fxs[8], fys[8];

    typedef struct {
        logic [1:0][N-1:0][PS-1:0] pos;
        logic [1:0][N-1:0][VS-1:0] vel;
        bit err;
    } exp_t;
    exp_t sb[$];

    function automatic int sat(int x, int bits);
        int lim = 1 << (bits - 1);
        if (x > lim - 1) return lim - 1;
        if (x < -lim) return -lim;
        return x;
    endfunction

    function automatic void model_apply(int i, int f_x, int f_y);
        int vx, vy, px, py;
        vx = sat(mvx[i] + (f_x >>> DT), VS);
        px = sat(mpx[i] + (vx >>> DT), PS);
        vy = sat(mvy[i] + ((f_y + G) >>> DT), VS);
        py = sat(mpy[i] + (vy >>> DT), PS);
        if (py < FLOOR) begin
            py = FLOOR;
            if (vy < 0) vy = 0;
        end
        mvx[i] = vx; mvy[i] = vy; mpx[i] = px; mpy[i] = py;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mpx[i] = 0; mpy[i] = 0; mvx[i] = 0; mvy[i] = 0;
        end
        merr = 1'b0;
    endfunction

    function automatic void push_expected();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.pos[0][i] = PS'(mpx[i]); e.pos[1][i] = PS'(mpy[i]);
            e.vel[0][i] = VS'(mvx[i]); e.vel[1][i] = VS'(mvy[i]);
        end
        e.err = merr;
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; step_trigger = 0; load_valid = 0; fvalid = 0; sdone = 0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic load(input int idx, input int px, input int py, input int vx, input int vy);
        load_valid = 1; load_idx = 2'(idx);
        load_pos_x = PS'(px); load_pos_y = PS'(py); load_vel_x = VS'(vx); load_vel_y = VS'(vy);
        mpx[idx] = px; mpy[idx] = py; mvx[idx] = vx; mvy[idx] = vy;
        tick();
        load_valid = 0;
    endtask

    // Wait for springs_start, then step once so the bench sits in COLLECT.
    task automatic wait_collect(input bit junk_load);
        bit ok = 0;
        for (int k = 0; k < 8; k++) begin
            if (springs_start) begin ok = 1; break; end
            tick();
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL springs_start_seen: got 0 expected 1"); end
        if (junk_load) begin
            load_valid = 1; load_idx = 2'd1;
            load_pos_x = 16'sd1234; load_pos_y = 16'sd4321; load_vel_x = 16'sd77; load_vel_y = -16'sd77;
        end
        tick();
        load_valid = 0;
    endtask

    task automatic start_step(input bit junk_load);
        step_trigger = 1;
        tick();
        step_trigger = 0;
        load_valid = 0;
        wait_collect(junk_load);
    endtask

    task automatic check_done_sb(input int max_wait);
        bit seen = 0;
        exp_t e;
        for (int k = 0; k < max_wait; k++) begin
            if (step_done) begin seen = 1; break; end
            tick();
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL step_done_seen: got 0 expected 1");
        end else if (sb.size() == 0) begin
            failures++; $display("FAIL scoreboard_empty: got step_done with no expected entry");
        end else begin
            e = sb.pop_front();
            checks++;
            if (nodes !== e.pos) begin
                failures++; $display("FAIL sb_nodes: got %h expected %h", nodes, e.pos);
            end
            checks++;
            if (velocities !== e.vel) begin
                failures++; $display("FAIL sb_velocities: got %h expected %h", velocities, e.vel);
            end
            checks++;
            if (error !== e.err) begin
                failures++; $display("FAIL sb_error: got %b expected %b", error, e.err);
            end
        end
    endtask

    // Streams nv forces from fxs/fys; springs_done goes with the last valid when coincide is set.
    task automatic run_step(input int nv, input bit coincide);
        int idx = 0;
        for (int i = 0; i < nv; i++) begin
            fvalid = 1; fx = FS'(fxs[i]); fy = FS'(fys[i]);
            if (coincide && i == nv - 1) sdone = 1;
            if (idx < N) begin model_apply(idx, fxs[i], fys[i]); idx++; end
            else merr = 1;
            tick();
        end
        fvalid = 0; fx = '0; fy = '0;
        if (!coincide || nv == 0) begin sdone = 1; tick(); end
        sdone = 0;
        if (idx < N) merr = 1;
        push_expected();
        check_done_sb(8);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (step_done !== 1'b0) begin failures++; $display("FAIL reset_step_done: got %b expected 0", step_done); end
        checks++; if (springs_start !== 1'b0) begin failures++; $display("FAIL reset_springs_start: got %b expected 0", springs_start); end
        checks++; if (overrun_count !== 8'd0) begin failures++; $display("FAIL reset_overrun: got %0d expected 0", overrun_count); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b expected 0", error); end
        checks++; if (nodes !== '0) begin failures++; $display("FAIL reset_nodes: got %h expected 0", nodes); end
        checks++; if (velocities !== '0) begin failures++; $display("FAIL reset_velocities: got %h expected 0", velocities); end
    endtask

    task automatic test_basic_step();
        int ss0, sd0;
        load(1, 100, 100, 0, 0);
        fxs = '{0, 16, 0, 0, 0, 0, 0, 0};
        fys = '{0, 8, 0, 0, 0, 0, 0, 0};
        ss0 = ss_cnt; sd0 = sd_cnt;
        step_trigger = 1; tick(); step_trigger = 0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_collect(0);
        run_step(4, 0);
        tick(); tick();
        checks++; if (ss_cnt - ss0 != 1) begin failures++; $display("FAIL basic_springs_start_pulses: got %0d expected 1", ss_cnt - ss0); end
        checks++; if (sd_cnt - sd0 != 1) begin failures++; $display("FAIL basic_step_done_pulses: got %0d expected 1", sd_cnt - sd0); end
        checks++; if (nodes[0][1] !== 16'd101 || nodes[1][1] !== 16'd100) begin
            failures++; $display("FAIL basic_node1_pos: got (%0d,%0d) expected (101,100)", $signed(nodes[0][1]), $signed(nodes[1][1])); end
        checks++; if (velocities[0][1] !== 16'd4 || velocities[1][1] !== 16'd0) begin
            failures++; $display("FAIL basic_node1_vel: got (%0d,%0d) expected (4,0)", $signed(velocities[0][1]), $signed(velocities[1][1])); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_floor();
        load(0, 0, 2, 0, -40);
        fxs = '{0, 0, 0, 0, 0, 0, 0, 0};
        fys = '{0, 0, 0, 0, 0, 0, 0, 0};
        start_step(0);
        run_step(4, 0);
        tick();
        checks++; if (nodes[1][0] !== 16'd0 || velocities[1][0] !== 16'd0) begin
            failures++; $display("FAIL floor_clamp: got y=%0d vy=%0d expected y=0 vy=0", $signed(nodes[1][0]), $signed(velocities[1][0])); end
    endtask

    task automatic test_saturation();
        load(2, 30000, 0, 32760, 0);
        load(3, 0, 100, -32760, 0);
        fxs = '{0, 0, 32767, -32768, 0, 0, 0, 0};
        fys = '{0, 0, 0, 0, 0, 0, 0, 0};
        start_step(0);
        run_step(4, 0);
        tick();
        checks++; if (velocities[0][2] !== 16'h7fff) begin failures++; $display("FAIL sat_vx_pos: got %h expected 7fff", velocities[0][2]); end
        checks++; if (nodes[0][2] !== 16'h7fff) begin failures++; $display("FAIL sat_px_pos: got %h expected 7fff", nodes[0][2]); end
        checks++; if (velocities[0][3] !== 16'h8000) begin failures++; $display("FAIL sat_vx_neg: got %h expected 8000", velocities[0][3]); end
    endtask

    task automatic test_load_rules();
        int ov0;
        ov0 = overrun_count;
        load_valid = 1; load_idx = 2'd0;
        load_pos_x = 16'sd500; load_pos_y = 16'sd500; load_vel_x = 16'sd40; load_vel_y = 16'sd0;
        mpx[0] = 500; mpy[0] = 500; mvx[0] = 40; mvy[0] = 0;
        fxs = '{8, -12, 20, 4, 0, 0, 0, 0};
        fys = '{64, 0, -4, 100, 0, 0, 0, 0};
        start_step(1);
        run_step(4, 0);
        tick();
        checks++; if (overrun_count !== 8'(ov0)) begin failures++; $display("FAIL load_busy_overrun: got %0d expected %0d", overrun_count, ov0); end
    endtask

    task automatic test_back_to_back();
        int sd0;
        do_reset();
        sd0 = sd_cnt;
        fxs = '{4, 8, 12, 16, 0, 0, 0, 0};
        fys = '{40, 40, 40, 40, 0, 0, 0, 0};
        start_step(0);
        for (int k = 0; k < 3; k++) begin step_trigger = 1; tick(); end
        step_trigger = 0;
        run_step(4, 0);
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_pending_busy: got %b expected 1", busy); end
        wait_collect(0);
        run_step(4, 0);
        tick(); tick();
        checks++; if (overrun_count !== 8'd2) begin failures++; $display("FAIL b2b_overrun: got %0d expected 2", overrun_count); end
        checks++; if (sd_cnt - sd0 != 2) begin failures++; $display("FAIL b2b_step_done_pulses: got %0d expected 2", sd_cnt - sd0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_final_busy: got %b expected 0", busy); end
    endtask

    task automatic test_stream_errors();
        int sd0;
        do_reset();
        load(2, 7, 9, 3, 5);
        load(3, -20, 50, -6, 2);
        fxs = '{32, -32, 64, -64, 5, 0, 0, 0};
        fys = '{16, 16, 16, 16, 5, 0, 0, 0};
        start_step(0);
        run_step(4, 1);
        tick();
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL coincident_done_error: got %b expected 0", error); end
        sd0 = sd_cnt;
        start_step(0);
        run_step(2, 0);
        tick();
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL short_stream_error: got %b expected 1", error); end
        checks++; if (sd_cnt - sd0 != 1) begin failures++; $display("FAIL short_stream_step_done: got %0d expected 1", sd_cnt - sd0); end
        do_reset();
        start_step(0);
        run_step(5, 0);
        tick();
    endtask

    task automatic test_watchdog_and_abort();
        int n = 0, sd0;
        do_reset();
        start_step(0);
        while (!step_done && n < TO + 10) begin tick(); n++; end
        checks++; if (n != TO) begin failures++; $display("FAIL watchdog_latency: got %0d expected %0d", n, TO); end
        merr = 1;
        push_expected();
        check_done_sb(1);
        tick();
        load(1, 11, 22, 33, 44);
        fxs = '{0, 0, 0, 0, 0, 0, 0, 0};
        start_step(0);
        fvalid = 1; fx = 16'sd100; fy = 16'sd100; tick();
        fvalid = 0;
        rst = 1; tick(); rst = 0;
        model_reset();
        sd0 = sd_cnt;
        checks++; if (busy !== 1'b0 || springs_start !== 1'b0 || step_done !== 1'b0) begin
            failures++; $display("FAIL abort_ctrl: got busy=%b start=%b done=%b expected 0", busy, springs_start, step_done); end
        checks++; if (error !== 1'b0 || overrun_count !== 8'd0) begin
            failures++; $display("FAIL abort_status: got error=%b overrun=%0d expected 0", error, overrun_count); end
        checks++; if (nodes !== '0 || velocities !== '0) begin
            failures++; $display("FAIL abort_state: got %h %h expected 0", nodes, velocities); end
        fvalid = 1; sdone = 1; fx = 16'sd50; fy = 16'sd50;
        tick(); tick(); tick();
        fvalid = 0; sdone = 0;
        tick();
        checks++; if (sd_cnt != sd0) begin failures++; $display("FAIL abort_no_step_done: got %0d expected 0", sd_cnt - sd0); end
        checks++; if (nodes !== '0 || error !== 1'b0) begin
            failures++; $display("FAIL abort_ignore_springs: got nodes=%h error=%b expected 0", nodes, error); end
    endtask

    initial begin
        test_reset();
        test_basic_step();
        test_floor();
        test_saturation();
        test_load_rules();
        test_back_to_back();
        test_stream_errors();
        test_watchdog_and_abort();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
